// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoder definitions: major opcodes, instruction formats, low-bit constant.
package instr_encoder_pkg;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam logic [1:0] INSTR_LOW_BITS = 2'b11;

  // Encoding matches the decoder's format signal.
  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_ILLEGAL = 3'd6
  } fmt_e;

  function automatic fmt_e fmt_of(input logic [4:0] opc);
    fmt_e f;
    case (opc)
      OPC_LUI, OPC_AUIPC:                 f = FMT_U;
      OPC_JAL:                            f = FMT_J;
      OPC_BRANCH:                         f = FMT_B;
      OPC_STORE:                          f = FMT_S;
      OPC_OP:                             f = FMT_R;
      OPC_LOAD, OPC_OP_IMM, OPC_JALR,
      OPC_MISC_MEM, OPC_SYSTEM:           f = FMT_I;
      default:                            f = FMT_ILLEGAL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_imm_pack.sv
// Places the immediate (and funct7 where the format carries it) into a 32-bit word mask.
// INSTR_ENCODER_IMM_CHECK_EN enables the immediate range check on o_imm_bad.
module instr_imm_pack
  import instr_encoder_pkg::*;
(
  input  fmt_e        i_fmt,
  input  logic [4:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_bits,
  output logic        o_imm_bad
);

  logic w_shift;
  assign w_shift = (i_opcode == OPC_OP_IMM) && ((i_funct3 == 3'b001) || (i_funct3 == 3'b101));

  always_comb begin
    o_bits = '0;
    case (i_fmt)
      FMT_R: o_bits[31:25] = i_funct7;
      FMT_I: begin
        if (w_shift) begin
          o_bits[31:25] = i_funct7;
          o_bits[24:20] = i_imm[4:0];
        end else begin
          o_bits[31:20] = i_imm[11:0];
        end
      end
      FMT_S: begin
        o_bits[31:25] = i_imm[11:5];
        o_bits[11:7]  = i_imm[4:0];
      end
      FMT_B: begin
        o_bits[31]    = i_imm[12];
        o_bits[30:25] = i_imm[10:5];
        o_bits[11:8]  = i_imm[4:1];
        o_bits[7]     = i_imm[11];
      end
      FMT_U: o_bits[31:12] = i_imm[31:12];
      FMT_J: begin
        o_bits[31]    = i_imm[20];
        o_bits[30:21] = i_imm[10:1];
        o_bits[20]    = i_imm[11];
        o_bits[19:12] = i_imm[19:12];
      end
      default: o_bits = '0;
    endcase
  end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
  always_comb begin
    o_imm_bad = 1'b0;
    case (i_fmt)
      FMT_I: begin
        if (w_shift) o_imm_bad = (i_imm[31:5] != '0);
        else         o_imm_bad = (i_imm[31:11] != '0) && (i_imm[31:11] != '1);
      end
      FMT_S: o_imm_bad = (i_imm[31:11] != '0) && (i_imm[31:11] != '1);
      FMT_B: o_imm_bad = ((i_imm[31:12] != '0) && (i_imm[31:12] != '1)) || i_imm[0];
      FMT_J: o_imm_bad = ((i_imm[31:20] != '0) && (i_imm[31:20] != '1)) || i_imm[0];
      FMT_U: o_imm_bad = (i_imm[11:0] != '0);
      default: o_imm_bad = 1'b0;
    endcase
  end
`else
  assign o_imm_bad = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder: two-stage valid/ready pipeline feeding IMEM with sequential addresses.
// INSTR_ENCODER_IMM_CHECK_EN enables immediate range checking (err_imm); otherwise err_imm stays 0.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              full,
  output logic              err_illegal,
  output logic              err_imm
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0]   r_issued;
  logic              r_s1_valid;
  fmt_e              r_s1_fmt;
  logic [4:0]        r_s1_opcode;
  logic [4:0]        r_s1_rd;
  logic [4:0]        r_s1_rs1;
  logic [4:0]        r_s1_rs2;
  logic [2:0]        r_s1_f3;
  logic [6:0]        r_s1_f7;
  logic [31:0]       r_s1_imm;
  logic [ADDR_W-1:0] r_s1_addr;
  logic              r_s2_valid;
  logic [31:0]       r_s2_data;
  logic [ADDR_W-1:0] r_s2_addr;
  logic              r_err_illegal;
  logic              r_err_imm;

  fmt_e        w_in_fmt;
  logic        w_in_legal;
  logic        w_full;
  logic        w_s2_free;
  logic        w_s1_adv;
  logic        w_accept;
  logic [31:0] w_imm_bits;
  logic        w_imm_bad;
  logic [31:0] w_word;

  assign w_in_fmt   = fmt_of(opcode);
  assign w_in_legal = (w_in_fmt != FMT_ILLEGAL);
  assign w_full     = (r_issued == DEPTH);
  assign w_s2_free  = !r_s2_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_free;
  assign in_ready   = !rst && !clear && !w_full && (!r_s1_valid || w_s2_free);
  assign w_accept   = in_valid && in_ready;

  instr_imm_pack u_imm_pack (
    .i_fmt     (r_s1_fmt),
    .i_opcode  (r_s1_opcode),
    .i_funct3  (r_s1_f3),
    .i_funct7  (r_s1_f7),
    .i_imm     (r_s1_imm),
    .o_bits    (w_imm_bits),
    .o_imm_bad (w_imm_bad)
  );

  always_comb begin
    w_word       = w_imm_bits;
    w_word[1:0]  = INSTR_LOW_BITS;
    w_word[6:2]  = r_s1_opcode;
    if (r_s1_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) w_word[11:7] = r_s1_rd;
    if (r_s1_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) begin
      w_word[14:12] = r_s1_f3;
      w_word[19:15] = r_s1_rs1;
    end
    if (r_s1_fmt inside {FMT_R, FMT_S, FMT_B}) w_word[24:20] = r_s1_rs2;
  end

  // Illegal bundles are accepted but never enter S1, so they take no address.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_issued      <= '0;
      r_s1_valid    <= 1'b0;
      r_s2_valid    <= 1'b0;
      r_s2_data     <= '0;
      r_s2_addr     <= '0;
      r_err_illegal <= 1'b0;
      r_err_imm     <= 1'b0;
    end else begin
      if (w_accept && w_in_legal) begin
        r_s1_valid <= 1'b1;
        r_issued   <= r_issued + 1'b1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_s2_data  <= w_word;
        r_s2_addr  <= r_s1_addr;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
      if (w_accept && !w_in_legal) r_err_illegal <= 1'b1;
      if (w_s1_adv && w_imm_bad)   r_err_imm     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_in_legal) begin
      r_s1_fmt    <= w_in_fmt;
      r_s1_opcode <= opcode;
      r_s1_rd     <= rd;
      r_s1_rs1    <= rs1;
      r_s1_rs2    <= rs2;
      r_s1_f3     <= funct3;
      r_s1_f7     <= funct7;
      r_s1_imm    <= imm;
      r_s1_addr   <= r_issued[ADDR_W-1:0];
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_data    = r_s2_data;
  assign out_addr    = r_s2_addr;
  assign full        = w_full;
  assign err_illegal = r_err_illegal;
  assign err_imm     = r_err_imm;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus random traffic against a scoreboard model.
`timescale 1ns/1ps
module tb_instr_encoder;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, clear, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]    opcode, rd, rs1, rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm, out_data;
  logic [AW-1:0] out_addr;
  logic          full, err_illegal, err_imm;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .full(full), .err_illegal(err_illegal), .err_imm(err_imm)
  );

  typedef struct { int unsigned addr; logic [31:0] data; bit bad; } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_mis = 0;
  int unsigned m_issued = 0;
  bit m_err_ill = 0, m_imm_any = 0, m_imm_must = 0;
  bit last_acc = 0;
  int n_acc = 0, n_pops = 0;
  logic [31:0] last_pop_data = '0;
  int unsigned last_pop_addr = 0;
  bit hold = 0;
  logic [31:0] hold_data;
  logic [AW-1:0] hold_addr;

  logic [4:0] legal_ops [11] = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                                 5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference encoder: {legal, word} built directly from the RV32I field layout.
  function automatic logic [32:0] ref_enc(input logic [4:0] op, input logic [4:0] d, input logic [4:0] s1,
                                          input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] im);
    logic [31:0] w;
    bit legal;
    w = '0; legal = 1;
    w[1:0] = 2'b11; w[6:2] = op;
    case (op)
      5'b01101, 5'b00101: begin w[11:7] = d; w[31:12] = im[31:12]; end
      5'b11011: begin
        w[11:7] = d; w[31] = im[20]; w[30:21] = im[10:1]; w[20] = im[11]; w[19:12] = im[19:12];
      end
      5'b11000: begin
        w[14:12] = f3; w[19:15] = s1; w[24:20] = s2;
        w[31] = im[12]; w[30:25] = im[10:5]; w[11:8] = im[4:1]; w[7] = im[11];
      end
      5'b01000: begin
        w[14:12] = f3; w[19:15] = s1; w[24:20] = s2; w[31:25] = im[11:5]; w[11:7] = im[4:0];
      end
      5'b01100: begin
        w[11:7] = d; w[14:12] = f3; w[19:15] = s1; w[24:20] = s2; w[31:25] = f7;
      end
      5'b00000, 5'b00100, 5'b11001, 5'b00011, 5'b11100: begin
        w[11:7] = d; w[14:12] = f3; w[19:15] = s1; w[31:20] = im[11:0];
        if (op == 5'b00100 && (f3 == 3'b001 || f3 == 3'b101)) begin
          w[31:25] = f7; w[24:20] = im[4:0];
        end
      end
      default: legal = 0;
    endcase
    return {legal, w};
  endfunction

  // Representability by signed range arithmetic.
  function automatic bit imm_bad(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] im);
    int s;
    bit b;
    s = signed'(im);
    case (op)
      5'b01101, 5'b00101: b = (im[11:0] != 0);
      5'b11011:           b = (s < -(1 << 20)) || (s >= (1 << 20)) || im[0];
      5'b11000:           b = (s < -4096) || (s >= 4096) || im[0];
      5'b01000:           b = (s < -2048) || (s > 2047);
      5'b00000, 5'b00100, 5'b11001, 5'b00011, 5'b11100:
        if (op == 5'b00100 && (f3 == 3'b001 || f3 == 3'b101)) b = (im > 32'd31);
        else                                                   b = (s < -2048) || (s > 2047);
      default:            b = 0;
    endcase
`ifndef INSTR_ENCODER_IMM_CHECK_EN
    b = 0;
`endif
    return b;
  endfunction

  // One clock: called just after a negedge with inputs driven; returns at the next negedge.
  task automatic cyc();
    bit acc, pop, rc;
    logic [32:0] e;
    exp_t x;
    #1;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    rc  = rst || clear;
    if (hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hold_data);
      chk("hold_addr", out_addr, hold_addr);
    end
    if (sb.size() == 0) chk("idle_valid", out_valid, 0);
    if (rc || m_issued == DEPTH) chk("ready_blocked", in_ready, 0);
    else if (out_ready)          chk("ready_flow", in_ready, 1);
    if (pop && sb.size() > 0) begin
      x = sb.pop_front();
      chk("data", out_data, x.data);
      chk("addr", out_addr, x.addr);
      last_pop_data = out_data;
      last_pop_addr = out_addr;
      n_pops++;
      if (x.bad) m_imm_must = 1;
    end
    hold      = out_valid && !out_ready && !rc;
    hold_data = out_data;
    hold_addr = out_addr;
    e = ref_enc(opcode, rd, rs1, rs2, funct3, funct7, imm);
    @(posedge clk);
    #1;
    last_acc = acc;
    if (acc) n_acc++;
    if (rc) begin
      sb.delete();
      m_issued = 0; m_err_ill = 0; m_imm_any = 0; m_imm_must = 0;
    end else if (acc) begin
      if (e[32]) begin
        x.addr = m_issued; x.data = e[31:0]; x.bad = imm_bad(opcode, funct3, imm);
        sb.push_back(x);
        m_issued++;
        if (x.bad) m_imm_any = 1;
      end else begin
        m_err_ill = 1;
      end
    end
    chk("full", full, m_issued == DEPTH);
    chk("err_illegal", err_illegal, m_err_ill);
    if (m_imm_must) chk("err_imm_set", err_imm, 1);
    if (!m_imm_any) chk("err_imm_clr", err_imm, 0);
    @(negedge clk);
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1;
    last_acc = 0;
    for (int i = 0; i < 20 && !last_acc; i++) cyc();
    chk("accept_timeout", last_acc, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    in_valid  = 0;
    out_ready = 1;
    for (int i = 0; i < 6; i++) cyc();
  endtask

  task automatic do_clear();
    clear = 1;
    cyc();
    clear = 0;
  endtask

  initial begin
    int acc0, pops0, r;
    rst = 1; clear = 0; in_valid = 0; out_ready = 0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_full", full, 0);
    chk("rst_err_illegal", err_illegal, 0);
    chk("rst_err_imm", err_imm, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 0;
    #1;
    chk("post_rst_ready", in_ready, 1);

    // ADDI x1,x0,5 latency
    out_ready = 1;
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
    chk("lat_edge_n", out_valid, 0);
    cyc();
    chk("lat_edge_n1", out_valid, 1);
    chk("addi_data", out_data, 32'h00500093);
    chk("addi_addr", out_addr, 0);
    drain();

    // back-to-back with stalled output
    do_clear();
    out_ready = 0;
    send(5'b01100, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);
    send(5'b01000, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
    opcode = 5'b00100; rd = 5'd4; funct3 = 3'b000; imm = 32'd1;
    in_valid = 1;
    acc0 = n_acc;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", in_ready, 0);
      cyc();
    end
    chk("stall_no_accept", n_acc - acc0, 0);
    in_valid = 0;
    chk("stall_data", out_data, 32'h002081B3);
    chk("stall_addr", out_addr, 0);
    out_ready = 1;
    cyc();
    chk("sw_data", out_data, 32'h0020A423);
    chk("sw_addr", out_addr, 1);
    drain();

    // BEQ x0,x0,-4
    send(5'b11000, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFFFFC);
    drain();
    chk("beq_data", last_pop_data, 32'hFE000EE3);

    // fill to capacity
    do_clear();
    out_ready = 1;
    for (int k = 0; k < 4; k++) send(5'b00100, 5'(k + 1), 5'd0, 5'd0, 3'b000, 7'd0, 32'(k));
    #1;
    chk("cap_full", full, 1);
    chk("cap_ready", in_ready, 0);
    opcode = 5'b00100; in_valid = 1;
    acc0 = n_acc;
    for (int i = 0; i < 4; i++) cyc();
    chk("cap_5th_rejected", n_acc - acc0, 0);
    drain();
    chk("cap_last_addr", last_pop_addr, 3);
    do_clear();
    chk("clear_full", full, 0);
    send(5'b00100, 5'd7, 5'd0, 5'd0, 3'b000, 7'd0, 32'd9);
    drain();
    chk("clear_next_addr", last_pop_addr, 0);

    // illegal opcode
    do_clear();
    send(5'b11111, 5'd1, 5'd1, 5'd1, 3'b000, 7'd0, 32'd0);
    chk("illegal_flag", err_illegal, 1);
    pops0 = n_pops;
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
    drain();
    chk("illegal_pops", n_pops - pops0, 1);
    chk("illegal_next_addr", last_pop_addr, 0);

    // reset mid-stream
    out_ready = 0;
    send(5'b00100, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3);
    cyc();
    chk("pre_rst_valid", out_valid, 1);
    rst = 1;
    cyc();
    rst = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_err_illegal", err_illegal, 0);
    chk("mid_rst_full", full, 0);

    // immediate 2048 on ADDI
    out_ready = 1;
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048);
    drain();
    chk("imm2048_data", last_pop_data, 32'h80000093);
`ifdef INSTR_ENCODER_IMM_CHECK_EN
    chk("imm2048_err", err_imm, 1);
`else
    chk("imm2048_err", err_imm, 0);
`endif

    // random traffic
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(0, 15));
      opcode   = (r < 11) ? legal_ops[r] : 5'($urandom);
      rd       = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct3   = 3'($urandom); funct7 = 7'($urandom);
      case ($urandom_range(0, 2))
        0:       imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        1:       imm = $urandom;
        default: imm = 32'($urandom_range(0, 31));
      endcase
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      clear     = (m_issued == DEPTH) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      cyc();
    end
    rst = 0; clear = 0;
    drain();
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
